// File: rtl/fu_alu_queue.sv
// Command FIFO feeding an external ALU through a CSR handshake sequencer.
// Each command walks OP1 load, OP2 load and compute, with a per-wait-state timeout.
module fu_alu_queue #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [OP_W-1:0]           cmd_aluop,
    input  logic [DATA_W-1:0]         cmd_op1,
    input  logic [DATA_W-1:0]         cmd_op2,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic                      res_err,
    output logic [OP_W-1:0]           alu_aluop,
    output logic [DATA_W-1:0]         alu_op1,
    output logic [DATA_W-1:0]         alu_op2,
    input  logic [DATA_W-1:0]         alu_op3,
    output logic [2:0]                csr_alu_in,
    input  logic [2:0]                csr_alu_out,
    output logic                      busy,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [7:0]                err_cnt
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = OP_W + 2 * DATA_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_OP1, LOAD_OP1, WAIT_OP2, LOAD_OP2, COMPUTE, DONE
    } state_t;

    state_t              state_reg;
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [ENT_W-1:0]    entry [QDEPTH];
    logic [TMO_W-1:0]    wait_cnt_reg;
    logic [OP_W-1:0]     alu_aluop_reg;
    logic [DATA_W-1:0]   alu_op1_reg, alu_op2_reg, res_data_reg;
    logic                res_valid_reg, res_err_reg;
    logic [2:0]          csr_alu_in_reg;
    logic [7:0]          err_cnt_reg;
    logic                push, pop, is_wait, exit_cond, timed_out;

    assign cmd_ready = (count_reg < CNT_W'(QDEPTH));
    assign push      = cmd_valid & cmd_ready & ~flush;
    assign pop       = (state_reg == IDLE) & (count_reg != '0) & ~flush;

    // Storage has no reset: occupancy is tracked solely by the pointers and count.
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        logic [ENT_W-1:0] entry_reg;
        always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PTR_W'(gi))
                entry_reg <= {cmd_aluop, cmd_op1, cmd_op2};
        end
        assign entry[gi] = entry_reg;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        is_wait   = (state_reg == WAIT_OP1) || (state_reg == WAIT_OP2) || (state_reg == COMPUTE);
        exit_cond = (state_reg == WAIT_OP1) ? csr_alu_out[0] :
                    (state_reg == WAIT_OP2) ? csr_alu_out[1] : csr_alu_out[2];
        timed_out = (wait_cnt_reg >= TMO_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            alu_aluop_reg  <= '0;
            alu_op1_reg    <= '0;
            alu_op2_reg    <= '0;
            res_data_reg   <= '0;
            res_valid_reg  <= 1'b0;
            res_err_reg    <= 1'b0;
            csr_alu_in_reg <= 3'b001;
            err_cnt_reg    <= '0;
        end else if (flush) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            res_valid_reg  <= 1'b0;
            csr_alu_in_reg <= 3'b001;
        end else if (is_wait && !exit_cond) begin
            if (timed_out) begin
                state_reg      <= DONE;
                res_data_reg   <= '0;
                res_err_reg    <= 1'b1;
                res_valid_reg  <= 1'b1;
                csr_alu_in_reg <= 3'b001;
                if (err_cnt_reg != 8'hFF)
                    err_cnt_reg <= err_cnt_reg + 8'd1;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + TMO_W'(1);
            end
        end else begin
            // csr_alu_in is set on the transition so it is valid for the whole target state.
            case (state_reg)
                IDLE: if (count_reg != '0) begin
                    {alu_aluop_reg, alu_op1_reg, alu_op2_reg} <= entry[rd_ptr_reg];
                    state_reg    <= WAIT_OP1;
                    wait_cnt_reg <= '0;
                end
                WAIT_OP1: begin
                    state_reg      <= LOAD_OP1;
                    csr_alu_in_reg <= 3'b011;
                end
                LOAD_OP1: begin
                    state_reg      <= WAIT_OP2;
                    wait_cnt_reg   <= '0;
                    csr_alu_in_reg <= 3'b001;
                end
                WAIT_OP2: begin
                    state_reg      <= LOAD_OP2;
                    csr_alu_in_reg <= 3'b101;
                end
                LOAD_OP2: begin
                    state_reg      <= COMPUTE;
                    wait_cnt_reg   <= '0;
                    csr_alu_in_reg <= 3'b000;
                end
                COMPUTE: begin
                    state_reg      <= DONE;
                    res_data_reg   <= alu_op3;
                    res_err_reg    <= 1'b0;
                    res_valid_reg  <= 1'b1;
                    csr_alu_in_reg <= 3'b001;
                end
                DONE: if (res_ready) begin
                    res_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_err    = res_err_reg;
    assign alu_aluop  = alu_aluop_reg;
    assign alu_op1    = alu_op1_reg;
    assign alu_op2    = alu_op2_reg;
    assign csr_alu_in = csr_alu_in_reg;
    assign err_cnt    = err_cnt_reg;
    assign q_count    = count_reg;
    assign busy       = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_fu_alu_queue.sv
// Scoreboard bench for fu_alu_queue: expected results queued at push, compared on result handshake.
module tb_fu_alu_queue;
    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int QDEPTH  = 4;
    localparam int TIMEOUT = 8;

    logic clk, reset, flush, cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
    logic [OP_W-1:0]   cmd_aluop, alu_aluop;
    logic [DATA_W-1:0] cmd_op1, cmd_op2, res_data, alu_op1, alu_op2, alu_op3;
    logic [2:0]        csr_alu_in, csr_alu_out;
    logic [$clog2(QDEPTH):0] q_count;
    logic [7:0]        err_cnt;

    fu_alu_queue #(.DATA_W(DATA_W), .OP_W(OP_W), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_aluop(cmd_aluop),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_aluop(alu_aluop), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
        .csr_alu_in(csr_alu_in), .csr_alu_out(csr_alu_out),
        .busy(busy), .q_count(q_count), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU model driven by the DUT's operand registers.
    function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return a ^ b;
        endcase
    endfunction
    always_comb alu_op3 = alu_fn(alu_aluop, alu_op1, alu_op2);

    logic [DATA_W:0] sb[$];
    logic [DATA_W:0] exp_r;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'({res_err, res_data}), 64'(0));
            end else begin
                exp_r = sb.pop_front();
                $display("result: data=0x%0h err=%0b expected data=0x%0h err=%0b",
                         res_data, res_err, exp_r[DATA_W-1:0], exp_r[DATA_W]);
                check("result", 64'({res_err, res_data}), 64'(exp_r));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input bit exp_err);
        cmd_valid = 1'b1;
        cmd_aluop = op;
        cmd_op1   = a;
        cmd_op2   = b;
        check("push_ready", 64'(cmd_ready), 64'(1));
        if (cmd_ready && !flush)
            sb.push_back(exp_err ? {1'b1, {DATA_W{1'b0}}} : {1'b0, alu_fn(op, a, b)});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_csr(input logic [2:0] v, input string tag);
        int n = 0;
        while (csr_alu_in !== v && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(csr_alu_in), 64'(v));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_state();
        check("rst_q_count", 64'(q_count), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_err", 64'(res_err), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_alu_regs", 64'({alu_aluop, alu_op1, alu_op2} != '0), 64'(0));
        check("rst_csr_in", 64'(csr_alu_in), 64'(3'b001));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [2:0] csr_exp [8];
        int n;
        int pushed;
        logic [OP_W-1:0]   r_op;
        logic [DATA_W-1:0] r_a, r_b;

        reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_aluop = '0;
        cmd_op1 = '0; cmd_op2 = '0; res_ready = 1'b1; csr_alu_out = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        tick();

        // Single op at minimum latency: 5 + 7 = 12, result visible 7 cycles after acceptance.
        csr_exp = '{3'b001, 3'b001, 3'b001, 3'b011, 3'b001, 3'b101, 3'b000, 3'b001};
        csr_alu_out = 3'b111;
        cmd_valid = 1'b1; cmd_aluop = 4'd0; cmd_op1 = 32'd5; cmd_op2 = 32'd7;
        sb.push_back({1'b0, 32'd12});
        for (int k = 1; k <= 7; k++) begin
            tick();
            cmd_valid = 1'b0;
            check("lat_res_valid", 64'(res_valid), 64'(k == 7));
            check("csr_in_seq", 64'(csr_alu_in), 64'(csr_exp[k]));
        end
        check("single_data", 64'(res_data), 64'(32'd12));
        tick();
        check("single_release", 64'(res_valid), 64'(0));

        // Timeout in WAIT_OP2, then backpressure with a second command queued.
        csr_alu_out = 3'b101;
        res_ready = 1'b0;
        push_cmd(4'd1, 32'd100, 32'd30, 1'b1);
        push_cmd(4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
        wait_csr(3'b011, "to_load_op1");
        n = 0;
        while (!res_valid && n < 30) begin
            tick();
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(9));
        check("timeout_err", 64'(res_err), 64'(1));
        check("timeout_data", 64'(res_data), 64'(0));
        check("timeout_err_cnt", 64'(err_cnt), 64'(1));
        csr_alu_out = 3'b111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_result", 64'({res_valid, res_err, res_data}), 64'({1'b1, 1'b1, 32'd0}));
            check("hold_no_pop", 64'(q_count), 64'(1));
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(res_valid), 64'(0));
        check("bp_release_q", 64'(q_count), 64'(1));
        tick();
        check("bp_next_pop_q", 64'(q_count), 64'(0));
        check("bp_next_pop_op1", 64'(alu_op1), 64'(32'h0000_F0F0));
        wait_idle("drain_bp");

        // Fill while a blocker sits in WAIT_OP1 until it times out.
        csr_alu_out = 3'b000;
        push_cmd(4'd3, 32'd11, 32'd22, 1'b1);
        tick();
        check("blocker_popped", 64'(q_count), 64'(0));
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_aluop = OP_W'(i % 4);
            cmd_op1   = DATA_W'(1000 + i);
            cmd_op2   = DATA_W'(3 * i + 1);
            check("fill_ready", 64'(cmd_ready), 64'(i < 4));
            if (cmd_ready)
                sb.push_back({1'b0, alu_fn(cmd_aluop, cmd_op1, cmd_op2)});
            tick();
        end
        cmd_valid = 1'b0;
        check("fill_q_count", 64'(q_count), 64'(4));
        n = 0;
        while (q_count != 3 && n < 40) begin
            tick();
            n++;
        end
        check("fill_first_pop", 64'(q_count), 64'(3));
        csr_alu_out = 3'b111;
        wait_idle("drain_fill");
        check("fill_err_cnt", 64'(err_cnt), 64'(2));

        // Flush while stuck in COMPUTE with two commands queued; a push in the flush cycle is dropped.
        csr_alu_out = 3'b011;
        push_cmd(4'd0, 32'd1, 32'd2, 1'b0);
        push_cmd(4'd0, 32'd3, 32'd4, 1'b0);
        push_cmd(4'd0, 32'd5, 32'd6, 1'b0);
        wait_csr(3'b000, "reach_compute");
        check("flush_pre_q", 64'(q_count), 64'(2));
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_op1 = 32'd77;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        sb.delete();
        check("flush_q_count", 64'(q_count), 64'(0));
        check("flush_csr_in", 64'(csr_alu_in), 64'(3'b001));
        check("flush_res_valid", 64'(res_valid), 64'(0));
        check("flush_err_cnt", 64'(err_cnt), 64'(2));
        repeat (3) tick();
        check("flush_push_dropped", 64'(busy), 64'(0));

        // Reset with flush asserted while in LOAD_OP2, one command still queued.
        csr_alu_out = 3'b111;
        push_cmd(4'd1, 32'd50, 32'd8, 1'b0);
        push_cmd(4'd1, 32'd60, 32'd9, 1'b0);
        wait_csr(3'b101, "reach_load_op2");
        reset = 1'b1;
        flush = 1'b1;
        tick();
        sb.delete();
        check_reset_state();
        reset = 1'b0;
        flush = 1'b0;
        tick();

        // Random traffic with random result backpressure.
        pushed = 0;
        n = 0;
        while (pushed < 8 && n < 500) begin
            r_op = OP_W'($urandom_range(0, 4));
            r_a  = $urandom;
            r_b  = $urandom;
            cmd_valid = 1'b1; cmd_aluop = r_op; cmd_op1 = r_a; cmd_op2 = r_b;
            if (cmd_ready) begin
                sb.push_back({1'b0, alu_fn(r_op, r_a, r_b)});
                pushed++;
            end
            res_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle("drain_random");
        repeat (2) tick();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fu_alu_queue.md
FU_ALU_QUEUE -- requirements
Module: fu_alu_queue

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
  DATA_W  32  operand/result width
  OP_W  4  ALU opcode width
  QDEPTH  4  command FIFO depth, power of 2, >=2
  TIMEOUT  255  max cycles in any wait state, >=4
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
  clk  in  1  clock
  reset  in  1  synchronous, active-high reset
  flush  in  1  synchronous abort of all queued/in-flight work
  cmd_valid  in  1  command offered
  cmd_ready  out  1  FIFO can accept
  cmd_aluop  in  OP_W  opcode
  cmd_op1  in  DATA_W  operand 1
  cmd_op2  in  DATA_W  operand 2
  res_valid  out  1  result held
  res_ready  in  1  consumer takes result
  res_data  out  DATA_W  result
  res_err  out  1  result is a timeout error
  alu_aluop  out  OP_W  opcode to external ALU
  alu_op1  out  DATA_W  operand 1 to ALU
  alu_op2  out  DATA_W  operand 2 to ALU
  alu_op3  in  DATA_W  ALU result
  csr_alu_in  out  3  [0] result protect, [1] OP1 stable, [2] OP2 stable
  csr_alu_out  in  3  [0] OP1 port ready, [1] OP2 port ready, [2] result valid
  busy  out  1  FSM not IDLE or FIFO non-empty
  q_count  out  $clog2(QDEPTH)+1  FIFO occupancy
  err_cnt  out  8  saturating timeout count

Function
REQ-003 SHALL hold commands {aluop, op1, op2} in a QDEPTH-entry FIFO; push when cmd_valid & cmd_ready; cmd_ready = (q_count < QDEPTH), combinational from registered count.
REQ-004 SHALL not accept a push when full, even if a pop occurs the same cycle; simultaneous push and pop when not full leaves q_count unchanged; pointers wrap modulo QDEPTH.
REQ-005 SHALL implement FSM: IDLE, WAIT_OP1, LOAD_OP1, WAIT_OP2, LOAD_OP2, COMPUTE, DONE.
REQ-006 IDLE: if q_count>0, pop head into alu_aluop/alu_op1/alu_op2 registers and go to WAIT_OP1; a command pushed this cycle into an empty FIFO pops no earlier than the next cycle.
REQ-007 WAIT_OP1 -> LOAD_OP1 when csr_alu_out[0]=1; LOAD_OP1 -> WAIT_OP2 unconditionally after one cycle.
REQ-008 WAIT_OP2 -> LOAD_OP2 when csr_alu_out[1]=1; LOAD_OP2 -> COMPUTE after one cycle.
REQ-009 COMPUTE -> DONE when csr_alu_out[2]=1, capturing alu_op3 into res_data, res_err=0, res_valid=1.
REQ-010 DONE: hold res_valid/res_data/res_err stable until res_valid & res_ready, then clear res_valid and go to IDLE.
REQ-011 csr_alu_in SHALL be registered: [1]=1 exactly in LOAD_OP1; [2]=1 exactly in LOAD_OP2; [0]=0 exactly in COMPUTE, 1 otherwise.
REQ-012 alu_aluop/alu_op1/alu_op2 SHALL remain stable from pop until the next pop.
REQ-013 A cycle counter SHALL clear on entry to WAIT_OP1, WAIT_OP2, COMPUTE and increment each cycle in those states; reaching TIMEOUT with the exit condition false forces DONE with res_data=0, res_err=1; err_cnt increments, saturating at 255.
REQ-014 Minimum latency: command accepted in cycle t yields res_valid=1 at t+7 when all csr_alu_out bits are already 1.
REQ-015 flush SHALL, next cycle: empty FIFO, FSM=IDLE, res_valid=0, csr_alu_in=3'b001; err_cnt is kept; a push in the flush cycle is discarded.

Reset
REQ-016 On reset: FSM=IDLE, FIFO empty, q_count=0, cmd_ready=1, res_valid=0, res_err=0, res_data=0, alu_* operand/opcode registers=0, csr_alu_in=3'b001, err_cnt=0, busy=0; reset overrides flush and applies mid-operation from any state.

Verification
REQ-017 Single op: push {aluop=0, op1=5, op2=7}, ALU returns op3=12 with csr_alu_out=3'b111 -> res_valid at t+7, res_data=12, res_err=0, csr_alu_in pulses 011,101,000 in order.
REQ-018 Fill: push 5 commands back-to-back with csr_alu_out=0 -> first 4 accepted, cmd_ready=0 on 5th, q_count=4 then 3 after first pop.
REQ-019 Backpressure: res_ready=0 for 10 cycles in DONE -> res_data unchanged, no further pop; res_ready=1 -> IDLE next cycle, next command pops.
REQ-020 Timeout: TIMEOUT=8, csr_alu_out[1] stuck 0 -> DONE after 8 cycles in WAIT_OP2, res_err=1, res_data=0, err_cnt=1.
REQ-021 Flush in COMPUTE with 2 queued -> next cycle IDLE, q_count=0, csr_alu_in=3'b001, res_valid=0.
REQ-022 Reset asserted in LOAD_OP2 with flush=1 -> all REQ-016 values next cycle.
